// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a scanned, active-low 4-digit 7-segment display drive.
// Define SEG7_DP_EN to add decimal-point capture (dp_in / dp_out).
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an_in,
  input  logic [6:0]  seg_in,
`ifdef SEG7_DP_EN
  input  logic        dp_in,
  output logic [3:0]  dp_out,
`endif
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  digit_err,
  output logic        frame_done
);

`ifdef SEG7_DP_EN
  localparam int unsigned SampleW = 12;
`else
  localparam int unsigned SampleW = 11;
`endif
  localparam logic [3:0] Stable = 4'(STABLE_CYCLES);

  logic [3:0]         an_s1_q, an_s2_q;
  logic [6:0]         seg_s1_q, seg_s2_q;
  logic [SampleW-1:0] sample, prev_q;
  logic [3:0]         cnt_q, cnt_d;
  logic [3:0]         sel;
  logic               sel_ok, changed, accept;
  logic [4:0]         dec;
  logic [15:0]        digits_q, digits_d;
  logic [3:0]         valid_q, valid_d, err_q, err_d, seen_q, seen_d, seen_nxt;
  logic               frame_q, frame_d;

`ifdef SEG7_DP_EN
  logic       dp_s1_q, dp_s2_q;
  logic [3:0] dp_q, dp_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_s1_q <= 1'b1;
      dp_s2_q <= 1'b1;
      dp_q    <= '0;
    end else begin
      dp_s1_q <= dp_in;
      dp_s2_q <= dp_s1_q;
      dp_q    <= dp_d;
    end
  end

  assign sample = {dp_s2_q, an_s2_q, seg_s2_q};
  assign dp_out = dp_q;
`else
  assign sample = {an_s2_q, seg_s2_q};
`endif

  // Returns {legal, nibble}; blank and illegal patterns both report legal=0.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40:   decode = 5'h10;
      7'h79:   decode = 5'h11;
      7'h24:   decode = 5'h12;
      7'h30:   decode = 5'h13;
      7'h19:   decode = 5'h14;
      7'h12:   decode = 5'h15;
      7'h02:   decode = 5'h16;
      7'h78:   decode = 5'h17;
      7'h00:   decode = 5'h18;
      7'h10:   decode = 5'h19;
      7'h08:   decode = 5'h1A;
      7'h03:   decode = 5'h1B;
      7'h46:   decode = 5'h1C;
      7'h21:   decode = 5'h1D;
      7'h06:   decode = 5'h1E;
      7'h0E:   decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1_q  <= '1;
      an_s2_q  <= '1;
      seg_s1_q <= '1;
      seg_s2_q <= '1;
      prev_q   <= '1;
      cnt_q    <= '0;
      digits_q <= '0;
      valid_q  <= '0;
      err_q    <= '0;
      seen_q   <= '0;
      frame_q  <= 1'b0;
    end else begin
      an_s1_q  <= an_in;
      an_s2_q  <= an_s1_q;
      seg_s1_q <= seg_in;
      seg_s2_q <= seg_s1_q;
      prev_q   <= sample;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      seen_q   <= seen_d;
      frame_q  <= frame_d;
    end
  end

  always_comb begin
    sel     = ~an_s2_q;
    sel_ok  = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
    // A cleared counter means the previous sample was not capturable.
    changed = (sample != prev_q) || (cnt_q == 4'd0);
    cnt_d   = cnt_q;
    if (!sel_ok) begin
      cnt_d = 4'd0;
    end else if (changed) begin
      cnt_d = 4'd1;
    end else if (cnt_q != 4'hF) begin
      cnt_d = cnt_q + 4'd1;
    end
    // Fire only on the edge the count arrives at Stable, not while it sits there saturated.
    accept = sel_ok && (cnt_d == Stable) && (changed || (cnt_q != cnt_d));
  end

  always_comb begin
    dec      = decode(seg_s2_q);
    digits_d = digits_q;
    valid_d  = valid_q;
    err_d    = err_q;
    seen_d   = seen_q;
    seen_nxt = seen_q | sel;
    frame_d  = 1'b0;
`ifdef SEG7_DP_EN
    dp_d     = dp_q;
`endif
    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) begin
          if (dec[4]) begin
            digits_d[i*4 +: 4] = dec[3:0];
            valid_d[i]         = 1'b1;
            err_d[i]           = 1'b0;
          end else if (seg_s2_q == 7'h7F) begin
            valid_d[i] = 1'b0;
            err_d[i]   = 1'b0;
          end else begin
            valid_d[i] = 1'b0;
            err_d[i]   = 1'b1;
          end
`ifdef SEG7_DP_EN
          dp_d[i] = ~dp_s2_q;
`endif
        end
      end
      if (seen_nxt == 4'hF) begin
        frame_d = 1'b1;
        seen_d  = 4'h0;
      end else begin
        seen_d  = seen_nxt;
      end
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign digit_err   = err_q;
  assign frame_done  = frame_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: run-length reference model on raw pin history.
// Compile with SEG7_DP_EN to exercise decimal-point capture.
module tb_seg7_scan_decoder;
  localparam int unsigned STABLE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an_in = 4'hF;
  logic [6:0]  seg_in = 7'h7F;
  logic        dp_in = 1'b1;
  logic [15:0] digits;
  logic [3:0]  digit_valid, digit_err, dp_got;
  logic        frame_done;

`ifdef SEG7_DP_EN
  logic [3:0] dp_out;
  assign dp_got = dp_out;
`else
  assign dp_got = 4'h0;
`endif

  seg7_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an_in       (an_in),
    .seg_in      (seg_in),
`ifdef SEG7_DP_EN
    .dp_in       (dp_in),
    .dp_out      (dp_out),
`endif
    .digits      (digits),
    .digit_valid (digit_valid),
    .digit_err   (digit_err),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  err;
    logic [3:0]  dp;
    logic        fd;
  } snap_t;

  snap_t       sb[$];
  int          checks = 0, errors = 0, fd_count = 0;
  logic [6:0]  glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0]  m_nib [4];
  logic [3:0]  m_valid, m_err, m_dp, m_seen;
  logic        m_fd;
  logic [11:0] hist[$];

  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (glyphs[i] == s) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic snap_t cur_snap();
    snap_t s;
    s.digits = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
    s.valid  = m_valid;
    s.err    = m_err;
    s.dp     = m_dp;
    s.fd     = m_fd;
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
    m_valid = 0; m_err = 0; m_dp = 0; m_seen = 0; m_fd = 0;
    hist.delete();
    // Two idle entries stand for what the synchronizer holds just after release.
    hist.push_back(12'hFFF);
    hist.push_back(12'hFFF);
  endtask

  // One clock edge worth of model: a sample is accepted when its run of identical
  // pin values, seen two edges later, has lasted exactly STABLE edges.
  task automatic model_edge();
    logic [11:0] s;
    logic [3:0]  sel;
    int          run, d, g;
    hist.push_back({dp_in, an_in, seg_in});
    if (hist.size() > 40) void'(hist.pop_front());
    s    = hist[hist.size()-3];
    sel  = ~s[10:7];
    m_fd = 1'b0;
    if ($countones(sel) == 1) begin
      run = 0;
      for (int j = hist.size() - 3; j >= 0; j--) begin
        if (hist[j] != s) break;
        run++;
      end
      if (run == STABLE) begin
        d = 0;
        for (int k = 0; k < 4; k++) if (sel[k]) d = k;
        g = lookup(s[6:0]);
        if (g >= 0) begin
          m_nib[d] = 4'(g); m_valid[d] = 1'b1; m_err[d] = 1'b0;
        end else if (s[6:0] == 7'h7F) begin
          m_valid[d] = 1'b0; m_err[d] = 1'b0;
        end else begin
          m_valid[d] = 1'b0; m_err[d] = 1'b1;
        end
        m_dp[d]   = ~s[11];
        m_seen[d] = 1'b1;
        if (m_seen == 4'hF) begin
          m_fd   = 1'b1;
          m_seen = 4'h0;
        end
      end
    end
    sb.push_back(cur_snap());
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    if (!rst_n) sb.push_back(snap_t'(0));
    else model_edge();
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input logic dp, input int n);
    an_in  = an;
    seg_in = seg;
`ifdef SEG7_DP_EN
    dp_in  = dp;
`else
    dp_in  = 1'b1 | dp;
`endif
    repeat (n) step();
  endtask

  always @(negedge clk) begin
    snap_t e;
    if (frame_done) fd_count++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("scoreboard", {3'b0, digits, digit_valid, digit_err, dp_got, frame_done},
            {3'b0, e});
    end
  end

  initial begin
    logic [15:0] d_save;
    logic [3:0]  v_save, e_save;
    int          fd_save;
    logic [3:0]  an_pick [7] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hF, 4'hC, 4'h0};
    logic [6:0]  sg;

    model_reset();
    repeat (3) step();
    check("reset_outputs", {11'b0, digits, digit_valid, digit_err, frame_done}, 32'h0);
    rst_n = 1'b1;

    // Single digit 0 = '2', accepted on the sixth edge.
    hold(4'hE, 7'h24, 1'b1, 6);
    check("first_digit", {digits[3:0], digit_valid[0], digit_err[0]}, {4'h2, 2'b10});

    // Full scan completes a frame.
    fd_save = fd_count;
    hold(4'hE, 7'h79, 1'b1, 8);
    hold(4'hD, 7'h30, 1'b1, 8);
    hold(4'hB, 7'h19, 1'b1, 8);
    hold(4'h7, 7'h0E, 1'b1, 8);
    @(negedge clk); #1;
    check("scan_digits", {16'b0, digits}, 32'hF431);
    check("scan_valid", {28'b0, digit_valid}, 32'hF);
    check("scan_frames", fd_count - fd_save, 32'd1);

    // Blank, then an illegal pattern, on digit 1.
    hold(4'hD, 7'h7F, 1'b1, 8);
    check("blank_d1", {digits[7:4], digit_valid[1], digit_err[1]}, {4'h3, 2'b00});
    hold(4'hD, 7'h55, 1'b1, 8);
    check("illegal_d1", {digits[7:4], digit_valid[1], digit_err[1]}, {4'h3, 2'b01});

    // Glitching segments never settle long enough; two-hot select never captures.
    d_save = digits; v_save = digit_valid; e_save = digit_err; fd_save = fd_count;
    for (int i = 0; i < 8; i++) hold(4'hB, glyphs[i], 1'b1, 3);
    hold(4'hC, 7'h40, 1'b1, 10);
    @(negedge clk); #1;
    check("glitch_hold", {4'b0, digits, v_save, e_save}, {4'b0, d_save, digit_valid, digit_err});
    check("glitch_frames", fd_count - fd_save, 32'd0);

    // Reset in the middle of a stable run.
    hold(4'hE, 7'h40, 1'b1, 3);
    #4;
    rst_n = 1'b0;
    #1;
    check("midrun_reset", {11'b0, digits, digit_valid, digit_err, frame_done}, 32'h0);
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    hold(4'hE, 7'h40, 1'b1, STABLE + 1);
    check("post_reset_early", {28'b0, digit_valid}, 32'h0);
    step();
    check("post_reset_accept", {28'b0, digit_valid}, 32'h1);

`ifdef SEG7_DP_EN
    hold(4'hB, 7'h12, 1'b0, 8);
    check("dp_digit2", {28'b0, dp_out}, 32'h4);
`endif

    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 6))
        0, 1, 2: sg = glyphs[$urandom_range(0, 15)];
        3:       sg = 7'h7F;
        default: sg = 7'($urandom);
      endcase
      hold(an_pick[$urandom_range(0, 6)], sg, 1'($urandom), $urandom_range(1, 8));
    end

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
